// File: rtl/des_key_sched_dec.sv
// des_key_sched_dec
//   Iterative DES key scheduler. On an accepted start the 64-bit key goes
//   through PC-1 once. Each delivered beat then rotates the C/D halves and
//   applies PC-2. With DECRYPT=1 the subkeys come out K16..K1 and the halves
//   rotate right. With DECRYPT=0 they come out K1..K16 and rotate left.
//   Subkeys leave over a valid/ready handshake, so the round datapath can
//   stall the schedule.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   start         request a new schedule; only honoured while idle
//   key_in[63:0]  DES key, DES bit 1 = key_in[63]; parity bits ignored
//   busy          high from the accepted start through the done cycle
//   subkey_valid  subkey/round_idx hold a subkey
//   subkey_ready  consumer takes the current subkey when high with valid
//   subkey[47:0]  PC-2 output, DES bit 1 = subkey[47]
//   round_idx     datapath round of the current beat, 0..15
//   done          one-cycle pulse after the 16th subkey is accepted
module des_key_sched_dec #(
  parameter bit DECRYPT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key_in,
  output logic        busy,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round_idx,
  output logic        done
);

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, FIN = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [47:0] subkey_q, subkey_d;
  logic [3:0]  round_q, round_d;

  logic [55:0] pc1_cd;
  logic [27:0] src_c, src_d, rot_c, rot_d;
  logic [3:0]  rot_idx;
  logic [1:0]  rot_amt;
  logic [55:0] rot_cd;
  logic [47:0] pc2_sk;
  logic        unused_parity;

  // DES numbers bits from the MSB. Bit p of the key is key_in[64-p], and
  // bit p of the 56-bit C||D register is cd[56-p].
  generate
    for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1_cd[55-gi] = key_in[64-PC1[gi]];
    end
    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
      assign pc2_sk[47-gi] = rot_cd[56-PC2[gi]];
    end
  endgenerate

  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8], key_in[0]};

  // Rotation applied before the PC-2 of beat r. The decrypt order starts
  // from C16/D16, which equals C0/D0 because the encrypt shifts total 28,
  // so its first beat needs no rotation.
  function automatic logic [1:0] shift_amt(input logic [3:0] r);
    logic [1:0] amt;
    if (r == 4'd1 || r == 4'd8 || r == 4'd15) amt = 2'd1;
    else if (r == 4'd0)                         amt = DECRYPT ? 2'd0 : 2'd1;
    else                                        amt = 2'd2;
    return amt;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] y;
    y = x;
    case (n)
      2'd1:    y = DECRYPT ? {x[0], x[27:1]}   : {x[26:0], x[27]};
      2'd2:    y = DECRYPT ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
      default: y = x;
    endcase
    return y;
  endfunction

  // In IDLE the rotator works on the fresh PC-1 value for beat 0. In EMIT it
  // works on the held halves and prepares the next beat.
  assign src_c   = (state_q == IDLE) ? pc1_cd[55:28] : c_q;
  assign src_d   = (state_q == IDLE) ? pc1_cd[27:0]  : d_q;
  assign rot_idx = (state_q == IDLE) ? 4'd0 : round_q + 4'd1;
  assign rot_amt = shift_amt(rot_idx);
  assign rot_c   = rot28(src_c, rot_amt);
  assign rot_d   = rot28(src_d, rot_amt);
  assign rot_cd  = {rot_c, rot_d};

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    d_d      = d_q;
    subkey_d = subkey_q;
    round_d  = round_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          c_d      = rot_c;
          d_d      = rot_d;
          subkey_d = pc2_sk;
          round_d  = 4'd0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (subkey_ready) begin
          if (round_q == 4'd15) begin
            state_d = FIN;
          end else begin
            c_d      = rot_c;
            d_d      = rot_d;
            subkey_d = pc2_sk;
            round_d  = round_q + 4'd1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      c_q      <= '0;
      d_q      <= '0;
      subkey_q <= '0;
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      d_q      <= d_d;
      subkey_q <= subkey_d;
      round_q  <= round_d;
    end
  end

  // All outputs decode registered state, so ready never reaches valid
  // combinationally.
  assign subkey_valid = (state_q == EMIT);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);
  assign subkey       = subkey_q;
  assign round_idx    = round_q;

endmodule

// File: tb/tb_des_key_sched_dec.sv
module tb_des_key_sched_dec;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] KEY0 = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_0  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_0 = 48'hCB3D8B0E17F5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, subkey_ready = 1'b1;
  logic [63:0] key_in = '0;
  logic        busy_dec, valid_dec, done_dec, busy_enc, valid_enc, done_enc;
  logic [47:0] sk_dec, sk_enc;
  logic [3:0]  ri_dec, ri_enc;

  des_key_sched_dec #(.DECRYPT(1'b1)) dut_dec (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy_dec),
    .subkey_valid(valid_dec), .subkey_ready(subkey_ready), .subkey(sk_dec),
    .round_idx(ri_dec), .done(done_dec));

  des_key_sched_dec #(.DECRYPT(1'b0)) dut_enc (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy_enc),
    .subkey_valid(valid_enc), .subkey_ready(subkey_ready), .subkey(sk_enc),
    .round_idx(ri_enc), .done(done_enc));

  int total = 0, bad = 0;
  int done_cnt [2] = '{0, 0};
  logic [51:0] q_dec [$], q_enc [$];
  logic [47:0] log_dec [$], log_enc [$];
  logic [47:0] ks_enc [16];
  logic        prev_stall [2] = '{1'b0, 1'b0};
  logic [47:0] prev_sk [2];
  logic [3:0]  prev_ri [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: K_i = PC-2 of C0/D0 rotated left by the running shift sum.
  task automatic compute_model(input logic [63:0] key);
    bit kb [64];
    bit cd0 [56];
    bit cdi [56];
    int tot;
    for (int p = 0; p < 64; p++) kb[p] = key[63-p];
    for (int i = 0; i < 56; i++) cd0[i] = kb[PC1_T[i]-1];
    tot = 0;
    for (int r = 0; r < 16; r++) begin
      tot += SHIFTS[r];
      for (int j = 0; j < 28; j++) begin
        cdi[j]    = cd0[(j + tot) % 28];
        cdi[28+j] = cd0[28 + (j + tot) % 28];
      end
      for (int o = 0; o < 48; o++) ks_enc[r][47-o] = cdi[PC2_T[o]-1];
    end
  endtask

  task automatic mon(input int inst, input logic v, input logic [47:0] sk,
                     input logic [3:0] ri, input logic dn);
    logic [51:0] e;
    logic        have;
    string       tag;
    tag = (inst == 0) ? "dec" : "enc";
    if (rst) begin
      prev_stall[inst] = 1'b0;
      return;
    end
    if (prev_stall[inst]) begin
      check({tag, "_stall_valid"}, 64'(v), 64'(1'b1));
      check({tag, "_stall_subkey"}, 64'(sk), 64'(prev_sk[inst]));
      check({tag, "_stall_round"}, 64'(ri), 64'(prev_ri[inst]));
    end
    if (v && subkey_ready) begin
      have = 1'b0;
      e = '0;
      if (inst == 0) begin
        if (q_dec.size() > 0) begin e = q_dec.pop_front(); have = 1'b1; end
      end else begin
        if (q_enc.size() > 0) begin e = q_enc.pop_front(); have = 1'b1; end
      end
      if (!have) begin
        total++;
        bad++;
        $display("FAIL %s_unexpected_beat actual=round %0d subkey %h required=no beat", tag, ri, sk);
      end else begin
        check({tag, "_subkey"}, 64'(sk), 64'(e[47:0]));
        check({tag, "_round"}, 64'(ri), 64'(e[51:48]));
        if (inst == 0) log_dec.push_back(sk); else log_enc.push_back(sk);
      end
    end
    prev_stall[inst] = v && !subkey_ready;
    prev_sk[inst] = sk;
    prev_ri[inst] = ri;
    if (dn) begin
      done_cnt[inst]++;
      check({tag, "_done_all_beats"}, 64'((inst == 0) ? q_dec.size() : q_enc.size()), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, valid_dec, sk_dec, ri_dec, done_dec);
    mon(1, valid_enc, sk_enc, ri_enc, done_enc);
  end

  task automatic issue(input logic [63:0] key);
    int w;
    w = 0;
    while ((busy_dec || busy_enc) && w < 100) begin @(posedge clk); #1; w++; end
    compute_model(key);
    for (int r = 0; r < 16; r++) begin
      q_dec.push_back({4'(r), ks_enc[15-r]});
      q_enc.push_back({4'(r), ks_enc[r]});
    end
    key_in = key;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!done_dec && n < 200);
    if (!done_dec) begin
      total++; bad++;
      $display("FAIL done_timeout actual=no done required=done within 200 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n;
    n = 0;
    while (!(valid_dec && ri_dec == r) && n < 100) begin @(posedge clk); #1; n++; end
    check("reach_round", 64'(ri_dec), 64'(r));
  endtask

  task automatic run_rand(input logic [63:0] key, input int pct);
    int n;
    int d0;
    d0 = done_cnt[0];
    issue(key);
    n = 0;
    while (!done_dec && n < 400) begin
      subkey_ready = ($urandom_range(0, 99) < pct);
      @(posedge clk); #1;
      n++;
    end
    subkey_ready = 1'b1;
    check("rand_done_seen", 64'(done_dec), 64'd1);
    @(posedge clk); #1;
    check("rand_done_once", 64'(done_cnt[0] - d0), 64'd1);
  endtask

  initial begin
    int n, d0, d1, st;
    logic [2:0] stalled;

    // Reset held with start=1: nothing may be accepted.
    rst = 1'b1; start = 1'b1; key_in = KEY0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    check("rst_busy", 64'({busy_dec, busy_enc}), 64'd0);
    check("rst_valid", 64'({valid_dec, valid_enc}), 64'd0);
    check("rst_subkey", 64'(sk_dec | sk_enc), 64'd0);
    check("rst_round", 64'({ri_dec, ri_enc}), 64'd0);
    check("rst_done", 64'({done_dec, done_enc}), 64'd0);
    @(posedge clk); #1;
    check("idle_after_rst", 64'(busy_dec), 64'd0);

    // Known vector, ready high: 16 back-to-back beats, done one cycle later.
    d0 = done_cnt[0]; d1 = done_cnt[1];
    issue(KEY0);
    check("latency_valid", 64'(valid_dec), 64'd1);
    check("latency_round", 64'(ri_dec), 64'd0);
    check("latency_busy", 64'(busy_dec), 64'd1);
    wait_done(n);
    check("done_cycle", 64'(n), 64'd17);
    check("after_done_busy", 64'(busy_dec), 64'd0);
    check("after_done_pulse", 64'(done_dec), 64'd0);
    check("done_once_dec", 64'(done_cnt[0] - d0), 64'd1);
    check("done_once_enc", 64'(done_cnt[1] - d1), 64'd1);
    check("log_len", 64'(log_dec.size()), 64'd16);
    if (log_dec.size() == 16 && log_enc.size() == 16) begin
      check("dec_beat0", 64'(log_dec[0]), 64'(K16_0));
      check("dec_beat15", 64'(log_dec[15]), 64'(K1_0));
      check("enc_beat0", 64'(log_enc[0]), 64'(K1_0));
      check("enc_beat15", 64'(log_enc[15]), 64'(K16_0));
      for (int r = 0; r < 16; r++)
        check("enc_is_dec_reversed", 64'(log_enc[r]), 64'(log_dec[15-r]));
    end
    log_dec.delete(); log_enc.delete();

    // Stall for 3 cycles at beats 0, 7 and 15.
    d0 = done_cnt[0];
    issue(KEY0);
    stalled = '0; st = 0; n = 0;
    while (!done_dec && n < 200) begin
      if (st > 0) begin
        st--;
        if (st == 0) subkey_ready = 1'b1;
      end else if (valid_dec && ri_dec == 4'd0 && !stalled[0]) begin
        stalled[0] = 1'b1; subkey_ready = 1'b0; st = 3;
      end else if (valid_dec && ri_dec == 4'd7 && !stalled[1]) begin
        stalled[1] = 1'b1; subkey_ready = 1'b0; st = 3;
      end else if (valid_dec && ri_dec == 4'd15 && !stalled[2]) begin
        stalled[2] = 1'b1; subkey_ready = 1'b0; st = 3;
      end
      @(posedge clk); #1;
      n++;
    end
    subkey_ready = 1'b1;
    check("stall_done_seen", 64'(done_dec), 64'd1);
    check("stall_cycles", 64'(n), 64'd25);
    @(posedge clk); #1;
    check("stall_done_once", 64'(done_cnt[0] - d0), 64'd1);
    check("stall_log_len", 64'(log_dec.size()), 64'd16);
    log_dec.delete(); log_enc.delete();

    // Start with another key during beat 5 is ignored; start on FIN too.
    d0 = done_cnt[0];
    issue(64'h0E329232EA6D0D73);
    wait_round(4'd5);
    key_in = 64'hFEDCBA9876543210; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done_dec && n < 100) begin @(negedge clk); n++; end
    check("ign_done_seen", 64'(done_dec), 64'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("fin_start_ignored", 64'(busy_dec), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_queued_start", 64'({busy_dec, valid_dec}), 64'd0);
    end
    check("ign_done_once", 64'(done_cnt[0] - d0), 64'd1);
    log_dec.delete(); log_enc.delete();

    // Reset mid-schedule at beat 9, then restart from beat 0.
    d0 = done_cnt[0];
    issue(KEY0);
    wait_round(4'd9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", 64'(valid_dec), 64'd0);
    check("midrst_busy", 64'(busy_dec), 64'd0);
    check("midrst_round", 64'(ri_dec), 64'd0);
    check("midrst_no_done", 64'(done_cnt[0] - d0), 64'd0);
    q_dec.delete(); q_enc.delete();
    log_dec.delete(); log_enc.delete();
    issue(KEY0);
    wait_done(n);
    check("restart_len", 64'(log_dec.size()), 64'd16);
    if (log_dec.size() > 0) check("restart_beat0", 64'(log_dec[0]), 64'(K16_0));
    log_dec.delete(); log_enc.delete();

    // Random keys with random ready throttling.
    for (int i = 0; i < 6; i++) begin
      run_rand({$urandom, $urandom}, 30 + 12 * i);
      log_dec.delete(); log_enc.delete();
    end

    repeat (2) @(posedge clk);
    check("final_queue_dec", 64'(q_dec.size()), 64'd0);
    check("final_queue_enc", 64'(q_enc.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
